mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter: WIDTH, default 3, count register width in bits.
REQ-002 Parameter: MODULUS, default 8, number of count states (0..MODULUS-1); legal range 2..2**WIDTH.
REQ-003 Parameter: WRAP_CNT_W, default 8, width of the wrap-event counter.
REQ-004 Port: clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: en  input  1  count enable.
REQ-007 Port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 Port: load  input  1  synchronous load strobe.
REQ-009 Port: load_val  input  WIDTH  value loaded when load=1.
REQ-010 Port: sat  input  1  saturate mode select; present only when MOD_COUNTER_SAT_EN is defined.
REQ-011 Port: out  output  WIDTH  current count.
REQ-012 Port: End  output  1  terminal-count flag.
REQ-013 Port: wrap  output  1  one-cycle wrap-event pulse.
REQ-014 Port: wraps  output  WRAP_CNT_W  number of wrap events since reset.

Function
REQ-015 Priority per posedge clk SHALL be load, then en, then hold.
REQ-016 load=1 SHALL set out to load_val, or to MODULUS-1 if load_val >= MODULUS; wrap=0 that cycle regardless of en.
REQ-017 en=1, up=1: out < MODULUS-1 -> out+1; out == MODULUS-1 -> 0 with wrap event.
REQ-018 en=1, up=0: out > 0 -> out-1; out == 0 -> MODULUS-1 with wrap event.
REQ-019 en=0 and load=0 SHALL hold out, wraps; wrap SHALL be 0.
REQ-020 End SHALL be decoded from registered out and current up: 1 iff (up && out==MODULUS-1) || (!up && out==0); zero added latency, no glitch-free guarantee required on up toggle.
REQ-021 wrap SHALL be registered, high for exactly the one cycle in which out first shows the wrapped value.
REQ-022 wraps SHALL increment on each wrap event and saturate at all-ones (no roll-over).
REQ-023 A direction change on the same cycle as a step SHALL use the new up value; no wrap unless the step itself crosses the boundary.
REQ-024 Arithmetic SHALL be WIDTH bits; no value >= MODULUS SHALL ever appear on out.

Reset
REQ-025 reset=1 SHALL immediately (asynchronously) force out=0, wrap=0, wraps=0; End then follows REQ-020 (1 if up=0).
REQ-026 Reset asserted mid-count SHALL discard any pending load/step; counting resumes on the first posedge clk after reset deasserts.

Configuration
REQ-027 Macro MOD_COUNTER_SAT_EN defined: when sat=1, a step that would wrap SHALL instead hold out at the terminal value, with no wrap pulse and no wraps increment; sat=0 behaves as wrap mode.
REQ-028 Macro MOD_COUNTER_SAT_EN undefined: sat port and saturation logic SHALL be absent; counter always wraps.

Structure
REQ-029 Shared package mod_counter_pkg SHALL hold the direction constants DIR_UP=1, DIR_DOWN=0 and the parameter-legality check (MODULUS in 2..2**WIDTH, elaboration error otherwise).
REQ-030 One sub-module, sat_event_counter (WRAP_CNT_W wide, increment strobe, saturating), SHALL implement wraps.

Verification
REQ-031 Defaults, en=1, up=1 from reset for 9 clocks -> out 1..7,0,1; End=1 only while out=7; wrap=1 only while out=0 after 7; wraps=1.
REQ-032 MODULUS=5, up=0, en=1 from out=0 -> out 4,3,2,1,0,4; End=1 at out=0; wrap pulse at each 0->4.
REQ-033 load=1, load_val=6, MODULUS=5, en=1 on the same clock -> out=4, wrap=0, End=1 (up=1).
REQ-034 WRAP_CNT_W=2, MODULUS=2, en=1 for 10 clocks -> wraps 1,2,3 then stays 3.
REQ-035 MOD_COUNTER_SAT_EN, sat=1, up=1, en=1 from out=6 -> out 7,7,7; wrap=0; wraps unchanged.
REQ-036 reset pulsed asynchronously between edges at out=5 -> out=0, wraps=0 before next edge; next edge with en=1, up=1 -> out=1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
//   Shared definitions for the modulo counter slice.
//   - DIR_UP / DIR_DOWN : encodings of the 'up' direction input.
//   - modulus_legal()   : parameter-legality check used at elaboration time
//                         (MODULUS must lie in 2..2**WIDTH).
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // True when 'modulus' count states fit in a 'width'-bit register and the
  // counter has at least two states to move between.
  function automatic bit modulus_legal(input int unsigned width,
                                       input int unsigned modulus);
    longint unsigned span;
    longint unsigned m;
    span = longint'(64'd1) << width;
    m    = longint'(modulus);
    return (m >= 64'd2) && (m <= span);
  endfunction

endpackage

// File: rtl/mod_counter_sat_event_counter.sv
// ---------------------------------------------------------------------------
// sat_event_counter
//   Saturating event counter: increments by one on each cycle in which the
//   increment strobe is high and sticks at all-ones instead of rolling over.
//
//   Ports
//     clk_i    : clock, state changes on rising edge
//     reset_i  : asynchronous active-high reset, clears the count
//     inc_i    : increment strobe (one event per high cycle)
//     count_o  : current event count, W bits
// ---------------------------------------------------------------------------
module sat_event_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Stop at the top value so a long-running counter never reads as small.
    if (inc_i && (count_q != ALL_ONES)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//   Up/down modulo-MODULUS counter with synchronous load, terminal-count
//   flag, registered wrap pulse and a saturating wrap-event counter.
//
//   Optional feature macro: MOD_COUNTER_SAT_EN
//     defined   -> 'sat' input present; with sat=1 a step that would wrap
//                  holds at the terminal value instead (no wrap event).
//     undefined -> no 'sat' port; the counter always wraps.
//
//   Parameters
//     WIDTH      : count register width
//     MODULUS    : number of count states 0..MODULUS-1 (2..2**WIDTH)
//     WRAP_CNT_W : width of the wrap-event counter
//
//   Ports
//     clk      : clock, all state changes on rising edge
//     reset    : asynchronous active-high reset
//     en       : count enable
//     up       : direction, 1 = increment, 0 = decrement
//     load     : synchronous load strobe (highest priority)
//     load_val : value to load, clamped to MODULUS-1
//     sat      : saturate-mode select (MOD_COUNTER_SAT_EN builds only)
//     out      : current count
//     End      : terminal-count flag for the current direction
//     wrap     : one-cycle pulse in the cycle out first shows a wrapped value
//     wraps    : number of wrap events since reset, saturating
// ---------------------------------------------------------------------------
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int MODULUS    = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
`ifdef MOD_COUNTER_SAT_EN
  input  logic                  sat,
`endif
  output logic [WIDTH-1:0]      out,
  output logic                  End,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wraps
);

  // Refuse to elaborate a counter whose states do not fit its register.
  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("mod_counter: MODULUS=%0d illegal for WIDTH=%0d (must be 2..2**WIDTH)",
           MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // MODULUS can equal 2**WIDTH, so compare load values one bit wider.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             sat_mode;
  logic             at_top;
  logic             at_bottom;

`ifdef MOD_COUNTER_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  assign at_top    = (cnt_q == MAX_VAL);
  assign at_bottom = (cnt_q == '0);

  // Next-state: load beats enable beats hold. Only a step that crosses the
  // boundary produces a wrap event; loads never do, even with en=1.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= MOD_EXT) begin
        cnt_d = MAX_VAL;
      end else begin
        cnt_d = load_val;
      end
    end else if (en) begin
      if (up == DIR_UP) begin
        if (at_top) begin
          if (!sat_mode) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (at_bottom) begin
          if (!sat_mode) begin
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // The wrap-event counter sees the same event that sets wrap_q, so wraps
  // and the wrap pulse update on the same edge.
  sat_event_counter #(
    .W (WRAP_CNT_W)
  ) u_wrap_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (wrap_d),
    .count_o (wraps)
  );

  // Terminal flag follows the live 'up' input with no register stage.
  assign End  = ((up == DIR_UP)   && at_top) ||
                ((up == DIR_DOWN) && at_bottom);
  assign out  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed testbench for mod_counter: three instances with different
// parameter sets share clock and reset, each with its own stimulus.
//   u0 : defaults (WIDTH=3, MODULUS=8, WRAP_CNT_W=8)
//   u1 : MODULUS=5
//   u2 : WIDTH=1, MODULUS=2, WRAP_CNT_W=2
module tb_mod_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       d0_en, d0_up, d0_load;
  logic [2:0] d0_load_val;
  logic [2:0] d0_out;
  logic       d0_end, d0_wrap;
  logic [7:0] d0_wraps;
`ifdef MOD_COUNTER_SAT_EN
  logic       d0_sat;
`endif

  logic       d1_en, d1_up, d1_load;
  logic [2:0] d1_load_val;
  logic [2:0] d1_out;
  logic       d1_end, d1_wrap;
  logic [7:0] d1_wraps;
`ifdef MOD_COUNTER_SAT_EN
  logic       d1_sat;
`endif

  logic       d2_en, d2_up, d2_load;
  logic [0:0] d2_load_val;
  logic [0:0] d2_out;
  logic       d2_end, d2_wrap;
  logic [1:0] d2_wraps;
`ifdef MOD_COUNTER_SAT_EN
  logic       d2_sat;
`endif

  mod_counter u0 (
    .clk(clk), .reset(reset), .en(d0_en), .up(d0_up), .load(d0_load),
    .load_val(d0_load_val),
`ifdef MOD_COUNTER_SAT_EN
    .sat(d0_sat),
`endif
    .out(d0_out), .End(d0_end), .wrap(d0_wrap), .wraps(d0_wraps)
  );

  mod_counter #(.WIDTH(3), .MODULUS(5), .WRAP_CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .en(d1_en), .up(d1_up), .load(d1_load),
    .load_val(d1_load_val),
`ifdef MOD_COUNTER_SAT_EN
    .sat(d1_sat),
`endif
    .out(d1_out), .End(d1_end), .wrap(d1_wrap), .wraps(d1_wraps)
  );

  mod_counter #(.WIDTH(1), .MODULUS(2), .WRAP_CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .en(d2_en), .up(d2_up), .load(d2_load),
    .load_val(d2_load_val),
`ifdef MOD_COUNTER_SAT_EN
    .sat(d2_sat),
`endif
    .out(d2_out), .End(d2_end), .wrap(d2_wrap), .wraps(d2_wraps)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0_out, e1_out;
    reset = 1'b1;
    d0_en = 0; d0_up = 1; d0_load = 0; d0_load_val = '0;
    d1_en = 0; d1_up = 0; d1_load = 0; d1_load_val = '0;
    d2_en = 0; d2_up = 1; d2_load = 0; d2_load_val = '0;
`ifdef MOD_COUNTER_SAT_EN
    d0_sat = 0; d1_sat = 0; d2_sat = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    // Reset state; End depends on direction.
    chk("rst_u0_out",   32'(d0_out),   0);
    chk("rst_u0_wrap",  32'(d0_wrap),  0);
    chk("rst_u0_wraps", 32'(d0_wraps), 0);
    chk("rst_u0_end",   32'(d0_end),   0);
    chk("rst_u1_end",   32'(d1_end),   1);
    chk("rst_u2_wraps", 32'(d2_wraps), 0);
    $display("reset: u0 out=%0d End=%0d, u1 End=%0d", d0_out, d0_end, d1_end);

    reset = 1'b0;
    d0_en = 1; d1_en = 1; d2_en = 1;
    // u0 counts up mod 8, u1 down mod 5, u2 up mod 2 with a 2-bit wraps.
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= 9) begin
        e0_out = k % 8;
        chk($sformatf("up8_k%0d_out", k),   32'(d0_out),   32'(e0_out));
        chk($sformatf("up8_k%0d_end", k),   32'(d0_end),   32'(e0_out == 7));
        chk($sformatf("up8_k%0d_wrap", k),  32'(d0_wrap),  32'(k == 8));
        chk($sformatf("up8_k%0d_wraps", k), 32'(d0_wraps), 32'(k >= 8));
        e1_out = (10 - k) % 5;
        chk($sformatf("dn5_k%0d_out", k),   32'(d1_out),   32'(e1_out));
        chk($sformatf("dn5_k%0d_end", k),   32'(d1_end),   32'(e1_out == 0));
        chk($sformatf("dn5_k%0d_wrap", k),  32'(d1_wrap),  32'(k % 5 == 1));
        chk($sformatf("dn5_k%0d_wraps", k), 32'(d1_wraps), (k >= 6) ? 2 : 1);
        $display("step %0d: u0 out=%0d wrap=%0d, u1 out=%0d wrap=%0d, u2 wraps=%0d",
                 k, d0_out, d0_wrap, d1_out, d1_wrap, d2_wraps);
      end else begin
        $display("step %0d: u2 out=%0d wraps=%0d", k, d2_out, d2_wraps);
      end
      chk($sformatf("m2_k%0d_out", k),   32'(d2_out),   32'(k % 2));
      chk($sformatf("m2_k%0d_wrap", k),  32'(d2_wrap),  32'(k % 2 == 0));
      chk($sformatf("m2_k%0d_wraps", k), 32'(d2_wraps), (k / 2 > 3) ? 3 : k / 2);
      if (k == 9) begin
        d0_en = 0; d1_en = 0;
      end
    end
    d2_en = 0;

    // Hold with en=0, load=0.
    step(); step();
    chk("hold_u0_out",   32'(d0_out),   1);
    chk("hold_u0_wrap",  32'(d0_wrap),  0);
    chk("hold_u0_wraps", 32'(d0_wraps), 1);
    chk("hold_u2_wraps", 32'(d2_wraps), 3);
    $display("hold: u0 out=%0d wraps=%0d", d0_out, d0_wraps);

    // Load clamp beats enable; no wrap on load.
    d1_load = 1; d1_load_val = 3'd6; d1_en = 1; d1_up = 1;
    step();
    chk("ld6_u1_out",  32'(d1_out),  4);
    chk("ld6_u1_wrap", 32'(d1_wrap), 0);
    chk("ld6_u1_end",  32'(d1_end),  1);
    $display("load 6: u1 out=%0d wrap=%0d End=%0d", d1_out, d1_wrap, d1_end);
    d1_load_val = 3'd4;
    step();
    chk("ld4_u1_out",   32'(d1_out),   4);
    chk("ld4_u1_wrap",  32'(d1_wrap),  0);
    chk("ld4_u1_wraps", 32'(d1_wraps), 2);
    $display("load 4 at top: u1 out=%0d wrap=%0d", d1_out, d1_wrap);
    d1_load = 0;
    step();
    chk("wrp_u1_out",   32'(d1_out),   0);
    chk("wrp_u1_wrap",  32'(d1_wrap),  1);
    chk("wrp_u1_wraps", 32'(d1_wraps), 3);
    chk("wrp_u1_end",   32'(d1_end),   0);
    $display("up wrap: u1 out=%0d wrap=%0d wraps=%0d", d1_out, d1_wrap, d1_wraps);
    d1_en = 0;

    // Direction changes take effect on the same step.
    d0_up = 0; d0_en = 1;
    step();
    chk("dir_dn_out",  32'(d0_out),  0);
    chk("dir_dn_wrap", 32'(d0_wrap), 0);
    chk("dir_dn_end",  32'(d0_end),  1);
    d0_up = 1;
    step();
    chk("dir_up_out",  32'(d0_out),  1);
    chk("dir_up_wrap", 32'(d0_wrap), 0);
    d0_up = 0;
    step();
    chk("dir_dn2_out", 32'(d0_out), 0);
    step();
    chk("dn_wrap_out",   32'(d0_out),   7);
    chk("dn_wrap_wrap",  32'(d0_wrap),  1);
    chk("dn_wrap_wraps", 32'(d0_wraps), 2);
    $display("down wrap: u0 out=%0d wrap=%0d wraps=%0d", d0_out, d0_wrap, d0_wraps);
    d0_en = 0;

    // End follows the live up input.
    d0_up = 1; #1;
    chk("end_up_at7", 32'(d0_end), 1);
    d0_up = 0; #1;
    chk("end_dn_at7", 32'(d0_end), 0);
    $display("End toggle: out=%0d End(up=0)=%0d", d0_out, d0_end);

`ifdef MOD_COUNTER_SAT_EN
    d0_load = 1; d0_load_val = 3'd6;
    step();
    chk("sat_ld_out", 32'(d0_out), 6);
    d0_load = 0; d0_sat = 1; d0_up = 1; d0_en = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("sat_k%0d_out", k),   32'(d0_out),   7);
      chk($sformatf("sat_k%0d_wrap", k),  32'(d0_wrap),  0);
      chk($sformatf("sat_k%0d_wraps", k), 32'(d0_wraps), 2);
      $display("sat step %0d: out=%0d wrap=%0d wraps=%0d", k, d0_out, d0_wrap, d0_wraps);
    end
    d0_sat = 0; d0_en = 0;
`endif

    // Asynchronous reset between edges at out=5.
    d0_load = 1; d0_load_val = 3'd5; d0_en = 0;
    step();
    chk("ar_ld_out", 32'(d0_out), 5);
    d0_load = 0; d0_en = 1; d0_up = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_u0_out",   32'(d0_out),   0);
    chk("ar_u0_wraps", 32'(d0_wraps), 0);
    chk("ar_u0_wrap",  32'(d0_wrap),  0);
    chk("ar_u1_wraps", 32'(d1_wraps), 0);
    chk("ar_u2_wraps", 32'(d2_wraps), 0);
    $display("async reset: u0 out=%0d wraps=%0d", d0_out, d0_wraps);
    reset = 1'b0;
    step();
    chk("ar_next_out",   32'(d0_out),   1);
    chk("ar_next_wraps", 32'(d0_wraps), 0);
    $display("after reset step: u0 out=%0d", d0_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
